matrix_uart_rx_parser: RTL and testbench

Receive-side counterpart of the matrix UART transmitter. It consumes the byte stream from the byte-level UART receiver (UartRx) and parses ASCII decimal tokens: optional header m, n, then m*n elements in row-major order. It packs the elements into the same 200-bit matrix bus layout the transmitter reads, with element (iy,ix) at byte (iy*n+ix). The control FSM starts it before matrix entry and reads matrixData/mOut/nOut when done pulses.

---
 rtl/matrix_uart_rx_parser_if.sv | 28 ++
 rtl/matrix_uart_rx_parser.sv | 167 ++++++++++++++++
 tb/tb_matrix_uart_rx_parser.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_uart_rx_parser_if.sv
// rtl/matrix_uart_rx_parser_if.sv - control, byte stream and result bundle of the matrix rx parser
interface matrix_uart_rx_parser_if #(
   parameter int DATA_W = 200
);
   logic              start;
   logic              hdrEn;
   logic [7:0]        mIn;
   logic [7:0]        nIn;
   logic [7:0]        rxData;
   logic              rxValid;
   logic [DATA_W-1:0] matrixData;
   logic [7:0]        mOut;
   logic [7:0]        nOut;
   logic              done;
   logic              busy;
   logic              error;
   logic [1:0]        errCode;

   modport master (
      output start, hdrEn, mIn, nIn, rxData, rxValid,
      input  matrixData, mOut, nOut, done, busy, error, errCode
   );

   modport slave (
      input  start, hdrEn, mIn, nIn, rxData, rxValid,
      output matrixData, mOut, nOut, done, busy, error, errCode
   );
endinterface

// File: rtl/matrix_uart_rx_parser.sv
// rtl/matrix_uart_rx_parser.sv - ASCII decimal matrix parser fed by the UART byte receiver
// Parses an optional m,n header then m*n row-major elements into a packed byte bus.
module matrix_uart_rx_parser #(
   parameter int MAX_DIM = 5,
   parameter int DATA_W  = 200
) (
   input logic                    clk,
   input logic                    uartRxRstN,
   matrix_uart_rx_parser_if.slave bus
);
   typedef enum logic [2:0] {IDLE, HDR_M, HDR_N, ELEM, ERR} state_t;

   localparam int         NUM_ELEM  = MAX_DIM * MAX_DIM;
   localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

   state_t            state_q, state_d;
   logic [7:0]        acc_q, acc_d;
   logic              in_tok_q, in_tok_d;
   logic [4:0]        idx_q, idx_d;
   logic [7:0]        m_q, m_d;
   logic [7:0]        n_q, n_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;

   logic              is_digit;
   logic              is_sep;
   logic              active;
   logic [11:0]       acc_next;
   logic [7:0]        elem_total;

   function automatic logic dim_ok(input logic [7:0] v);
      return (v != 8'd0) && (v <= MAX_DIM_B);
   endfunction

   assign is_digit   = (bus.rxData >= 8'h30) && (bus.rxData <= 8'h39);
   assign is_sep     = (bus.rxData == 8'h20) || (bus.rxData == 8'h0A) ||
                       (bus.rxData == 8'h0D) || (bus.rxData == 8'h09);
   assign active     = (state_q == HDR_M) || (state_q == HDR_N) || (state_q == ELEM);
   // Widened so an overflowing token is detected before it is truncated.
   assign acc_next   = ({4'd0, acc_q} * 12'd10) + {8'd0, bus.rxData[3:0]};
   assign elem_total = {4'd0, m_q[3:0]} * {4'd0, n_q[3:0]};

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      in_tok_d = in_tok_q;
      idx_d    = idx_q;
      m_d      = m_q;
      n_d      = n_q;
      data_d   = data_q;
      done_d   = 1'b0;
      err_d    = err_q;
      code_d   = code_q;

      if (bus.start) begin
         data_d   = '0;
         err_d    = 1'b0;
         code_d   = 2'd0;
         acc_d    = 8'd0;
         in_tok_d = 1'b0;
         idx_d    = 5'd0;
         if (bus.hdrEn) begin
            m_d     = 8'd0;
            n_d     = 8'd0;
            state_d = HDR_M;
         end else begin
            m_d = bus.mIn;
            n_d = bus.nIn;
            if (dim_ok(bus.mIn) && dim_ok(bus.nIn)) begin
               state_d = ELEM;
            end else begin
               state_d = ERR;
               err_d   = 1'b1;
               code_d  = 2'd3;
            end
         end
      end else if (bus.rxValid && active) begin
         if (is_digit) begin
            if (acc_next > 12'd255) begin
               state_d = ERR;
               err_d   = 1'b1;
               code_d  = 2'd2;
            end else begin
               acc_d    = acc_next[7:0];
               in_tok_d = 1'b1;
            end
         end else if (is_sep) begin
            if (in_tok_q) begin
               acc_d    = 8'd0;
               in_tok_d = 1'b0;
               case (state_q)
                  HDR_M: begin
                     if (dim_ok(acc_q)) begin
                        m_d     = acc_q;
                        state_d = HDR_N;
                     end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                     end
                  end
                  HDR_N: begin
                     if (dim_ok(acc_q)) begin
                        n_d     = acc_q;
                        state_d = ELEM;
                     end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                     end
                  end
                  default: begin
                     for (int k = 0; k < NUM_ELEM; k++) begin
                        if (idx_q == 5'(k)) data_d[k*8 +: 8] = acc_q;
                     end
                     idx_d = idx_q + 5'd1;
                     if (({3'd0, idx_q} + 8'd1) == elem_total) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end
               endcase
            end
         end else begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge uartRxRstN) begin
      if (!uartRxRstN) begin
         state_q  <= IDLE;
         acc_q    <= 8'd0;
         in_tok_q <= 1'b0;
         idx_q    <= 5'd0;
         m_q      <= 8'd0;
         n_q      <= 8'd0;
         data_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         in_tok_q <= in_tok_d;
         idx_q    <= idx_d;
         m_q      <= m_d;
         n_q      <= n_d;
         data_q   <= data_d;
         done_q   <= done_d;
         err_q    <= err_d;
         code_q   <= code_d;
      end
   end

   assign bus.matrixData = data_q;
   assign bus.mOut       = m_q;
   assign bus.nOut       = n_q;
   assign bus.done       = done_q;
   assign bus.busy       = active;
   assign bus.error      = err_q;
   assign bus.errCode    = code_q;
endmodule

// File: tb/tb_matrix_uart_rx_parser.sv
// tb/tb_matrix_uart_rx_parser.sv - randomized and directed checks of the matrix rx parser
module tb_matrix_uart_rx_parser;
   localparam int DW = 200;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matrix_uart_rx_parser_if #(.DATA_W(DW)) bus();

   matrix_uart_rx_parser #(.MAX_DIM(5), .DATA_W(DW)) dut (
      .clk        (clk),
      .uartRxRstN (rst_n),
      .bus        (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: phase 0 idle, 1 expecting m, 2 expecting n, 3 elements, 4 error
   int           ph = 0;
   int           acc = 0, tok = 0, cnt = 0;
   int           e_m = 0, e_n = 0, e_err = 0, e_code = 0, e_done = 0;
   byte unsigned elem [25];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit dim_ok(input int v);
      return (v >= 1) && (v <= 5);
   endfunction

   function automatic logic [DW-1:0] exp_data();
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < 25; k++) d[k*8 +: 8] = elem[k];
      return d;
   endfunction

   task automatic go_err(input int c);
      ph     = 4;
      e_err  = 1;
      e_code = c;
   endtask

   task automatic model_step();
      int v;
      int b;
      e_done = 0;
      if (bus.start) begin
         foreach (elem[k]) elem[k] = 8'd0;
         e_err = 0; e_code = 0; acc = 0; tok = 0; cnt = 0;
         if (bus.hdrEn) begin
            ph = 1; e_m = 0; e_n = 0;
         end else begin
            e_m = int'(bus.mIn);
            e_n = int'(bus.nIn);
            if (dim_ok(e_m) && dim_ok(e_n)) ph = 3;
            else go_err(3);
         end
      end else if (bus.rxValid && ph >= 1 && ph <= 3) begin
         b = int'(bus.rxData);
         if (b >= 48 && b <= 57) begin
            acc = acc * 10 + (b - 48);
            tok = 1;
            if (acc > 255) go_err(2);
         end else if (b == 32 || b == 10 || b == 13 || b == 9) begin
            if (tok != 0) begin
               v = acc; acc = 0; tok = 0;
               if (ph == 1) begin
                  if (dim_ok(v)) begin e_m = v; ph = 2; end
                  else go_err(3);
               end else if (ph == 2) begin
                  if (dim_ok(v)) begin e_n = v; ph = 3; end
                  else go_err(3);
               end else begin
                  elem[cnt] = 8'(v);
                  cnt++;
                  if (cnt == e_m * e_n) begin ph = 0; e_done = 1; end
               end
            end
         end else begin
            go_err(1);
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = 0; acc = 0; tok = 0; cnt = 0;
         e_m = 0; e_n = 0; e_err = 0; e_code = 0; e_done = 0;
         foreach (elem[k]) elem[k] = 8'd0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      chk("done",    256'(bus.done),       256'(e_done));
      chk("busy",    256'(bus.busy),       256'(ph >= 1 && ph <= 3));
      chk("error",   256'(bus.error),      256'(e_err));
      chk("errCode", 256'(bus.errCode),    256'(e_code));
      chk("mOut",    256'(bus.mOut),       256'(e_m));
      chk("nOut",    256'(bus.nOut),       256'(e_n));
      chk("data",    256'(bus.matrixData), 256'(exp_data()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.rxValid = 1'b0;
      bus.rxData  = 8'($urandom);
   endtask

   task automatic do_start(input bit hdr, input int m, input int n);
      bus.start = 1'b1;
      bus.hdrEn = hdr;
      bus.mIn   = 8'(m);
      bus.nIn   = 8'(n);
      tick();
   endtask

   task automatic send_byte(input byte unsigned b, input int gap);
      repeat (gap) tick();
      bus.rxValid = 1'b1;
      bus.rxData  = b;
      tick();
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, 1));
   endtask

   function automatic string num_str(input int v);
      string s;
      s = $sformatf("%0d", v);
      repeat ($urandom_range(0, 2)) s = {"0", s};
      return s;
   endfunction

   function automatic string sep_str();
      string s;
      string pool [4];
      pool[0] = " "; pool[1] = "\n"; pool[2] = "\r"; pool[3] = "\t";
      s = "";
      repeat ($urandom_range(1, 2)) s = {s, pool[$urandom_range(0, 3)]};
      return s;
   endfunction

   task automatic rand_stream();
      bit    hdr;
      int    m, n, bad_at, v;
      string s;
      hdr    = 1'($urandom_range(0, 1));
      m      = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
      n      = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
      bad_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 25) : -1;
      s      = "";
      do_start(hdr, m, n);
      if (hdr) s = {num_str(m), sep_str(), num_str(n), sep_str()};
      for (int i = 0; i < m * n; i++) begin
         v = $urandom_range(0, 255);
         if (i == bad_at) begin
            if ($urandom_range(0, 1) == 1) s = {s, num_str($urandom_range(256, 999)), sep_str()};
            else s = {s, num_str(v), ($urandom_range(0, 1) == 1) ? "a" : ",", sep_str()};
         end else begin
            s = {s, num_str(v), sep_str()};
         end
      end
      if ($urandom_range(0, 2) == 0) s = {s, "5"};
      send_str(s);
      repeat ($urandom_range(1, 3)) tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.hdrEn = 1'b0; bus.mIn = 8'd0; bus.nIn = 8'd0;
      bus.rxData = 8'd0; bus.rxValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 256'(bus.matrixData), 256'd0);
      chk("rst_busy", 256'(bus.busy), 256'd0);
      chk("rst_done", 256'(bus.done), 256'd0);
      chk("rst_err",  256'(bus.error), 256'd0);
      chk("rst_mOut", 256'(bus.mOut), 256'd0);
      rst_n = 1'b1;
      tick();

      // header stream, done exactly one clock after the final LF
      do_start(1'b1, 0, 0);
      chk("t1_busy_armed", 256'(bus.busy), 256'd1);
      send_str("2 3\n1 2 3\n4 5 6");
      chk("t1_no_early_done", 256'(bus.done), 256'd0);
      send_byte(8'h0A, 0);
      chk("t1_done", 256'(bus.done), 256'd1);
      chk("t1_busy_low", 256'(bus.busy), 256'd0);
      chk("t1_m", 256'(bus.mOut), 256'd2);
      chk("t1_n", 256'(bus.nOut), 256'd3);
      chk("t1_data", 256'(bus.matrixData), 256'h060504030201);
      tick();
      chk("t1_done_pulse", 256'(bus.done), 256'd0);

      // fixed dims, leading zeros, double separator
      do_start(1'b0, 1, 2);
      send_str("255  0007");
      send_byte(8'h0D, 0);
      chk("t2_done", 256'(bus.done), 256'd1);
      chk("t2_data", 256'(bus.matrixData[15:0]), 256'h07FF);
      chk("t2_err", 256'(bus.error), 256'd0);
      send_byte(8'h0A, 0);

      // value overflow
      do_start(1'b1, 0, 0);
      send_str("2 2\n1 256");
      chk("t3_err", 256'(bus.error), 256'd1);
      chk("t3_code", 256'(bus.errCode), 256'd2);
      chk("t3_busy", 256'(bus.busy), 256'd0);
      send_str(" 7 8 9\n");
      chk("t3_sticky", 256'(bus.errCode), 256'd2);

      // bad dimension, then a clean restart
      do_start(1'b1, 0, 0);
      send_str("6 ");
      chk("t4_code", 256'(bus.errCode), 256'd3);
      send_str("1\n");
      do_start(1'b1, 0, 0);
      chk("t4_cleared", 256'(bus.error), 256'd0);
      send_str("1 1\n9\n");
      chk("t4_data", 256'(bus.matrixData[7:0]), 256'h09);

      // illegal char, then a digit after completion
      do_start(1'b1, 0, 0);
      send_str("1 1\n4a");
      chk("t5_code", 256'(bus.errCode), 256'd1);
      do_start(1'b1, 0, 0);
      send_str("1 1\n7");
      send_byte(8'h0A, 0);
      chk("t5_done", 256'(bus.done), 256'd1);
      send_str("9");
      chk("t5_data", 256'(bus.matrixData[7:0]), 256'h07);
      chk("t5_idle", 256'(bus.busy), 256'd0);

      // restart mid-parse, and start colliding with a byte
      do_start(1'b1, 0, 0);
      send_str("2 2\n1 2 ");
      bus.rxValid = 1'b1;
      bus.rxData  = 8'h33;
      do_start(1'b1, 0, 0);
      chk("t6_cleared", 256'(bus.matrixData), 256'd0);
      send_str("2 2\n9 8 7 6\n");
      chk("t6_data", 256'(bus.matrixData), 256'h06070809);
      chk("t6_m", 256'(bus.mOut), 256'd2);

      // asynchronous reset mid-token
      do_start(1'b1, 0, 0);
      send_str("2 2\n4 1");
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_data", 256'(bus.matrixData), 256'd0);
      chk("t7_m", 256'(bus.mOut), 256'd0);
      chk("t7_busy", 256'(bus.busy), 256'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      send_str(" 5 6\n");
      chk("t7_quiet", 256'(bus.busy), 256'd0);

      for (int r = 0; r < 40; r++) rand_stream();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
